// File: rtl/bus_sizer_pkg.sv
// bus_sizer_pkg: shared types and helpers for the word-to-narrow-bus sizer.
//   state_t   - sizer FSM states (IDLE/WAIT/SAMPLE/DONE)
//   lane_bits - width of the lane index for R = WORD_BITS/NARROW_BITS lanes
package bus_sizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // R is 2 or 4, so one or two lane-select bits.
    function automatic int lane_bits(input int r);
        return (r > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bus_sizer_if.sv
// bus_sizer_if: CPU-side and narrow-bus signals of the sizer.
//   master modport: the CPU/bus environment (drives clk_en, memen, start, we,
//                   sysrdy, d8, q; observes the sizer outputs)
//   slave modport : the sizer itself
//
// Handshake: a CPU access is requested by memen & start (sampled only on
// clk_en ticks while idle); ready low means the CPU must hold memen and its
// write data until ready returns high. On the narrow side memen8 is the
// request and sysrdy the completion: a narrow cycle finishes on the first
// clk_en tick in the sample phase with sysrdy high. Dropping memen while
// ready is low aborts the access.
interface bus_sizer_if
    import bus_sizer_pkg::*;
#(
    parameter int WORD_BITS   = 16,
    parameter int NARROW_BITS = 8,
    parameter int LANE_W      = lane_bits(WORD_BITS / NARROW_BITS)
) ();

    logic                   clk_en;
    logic                   memen;
    logic                   start;
    logic                   we;
    logic                   sysrdy;
    logic [NARROW_BITS-1:0] d8;
    logic [WORD_BITS-1:0]   q;
    logic                   ready;
    logic                   memen8;
    logic                   we8;
    logic [LANE_W-1:0]      lane;
    logic [NARROW_BITS-1:0] q8;
    logic [WORD_BITS-1:0]   d;
    logic                   busy;
    state_t                 state;   // FSM state, for debug/observation

    modport master (
        output clk_en, memen, start, we, sysrdy, d8, q,
        input  ready, memen8, we8, lane, q8, d, busy, state
    );

    modport slave (
        input  clk_en, memen, start, we, sysrdy, d8, q,
        output ready, memen8, we8, lane, q8, d, busy, state
    );

endinterface

// File: rtl/bus_sizer_timer.sv
// bus_sizer_timer: wait-state counter for one narrow cycle.
//   clk, reset  - clock, asynchronous active-high reset
//   clk_en      - counter advances only on enabled ticks
//   load        - clear the count (held while not in the wait phase)
//   wait_states - number of wait ticks per narrow cycle (0-15)
//   expired     - this tick is the last wait tick (always 1 when wait_states=0)
module bus_sizer_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       load,
    input  logic [3:0] wait_states,
    output logic       expired
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        // Counting from 0, the wait phase ends on the tick where the count
        // would reach wait_states.
        expired = (wait_states == 4'd0) || ((cnt_q + 4'd1) == wait_states);
        cnt_d   = cnt_q;
        if (clk_en) begin
            if (load) begin
                cnt_d = 4'd0;
            end else if (!expired) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_sizer.sv
// bus_sizer: splits one CPU word access into R = WORD_BITS/NARROW_BITS narrow
// cycles, holds the CPU not-ready meanwhile and assembles read data.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - bus_sizer_if slave: CPU request/data, narrow-bus strobes,
//                lane select, write lane data, assembled read word, busy,
//                FSM state
// Lane k lives in bits [(R-1-k)*NARROW_BITS +: NARROW_BITS] of the word, so
// lane R-1 is the least significant slice.
module bus_sizer
    import bus_sizer_pkg::*;
#(
    parameter int WORD_BITS   = 16,
    parameter int NARROW_BITS = 8,
    parameter int WAIT_STATES = 4,
    parameter int LOW_FIRST   = 1
) (
    input  logic       clk,
    input  logic       reset,
    bus_sizer_if.slave bus
);

    localparam int R      = WORD_BITS / NARROW_BITS;
    localparam int LANE_W = lane_bits(R);
    localparam logic [LANE_W-1:0] LANE_START = LANE_W'((LOW_FIRST != 0) ? R - 1 : 0);
    localparam logic [LANE_W-1:0] LANE_LAST_CNT = LANE_W'(R - 1);
    // With no wait states the wait phase is skipped entirely.
    localparam state_t CYCLE_ENTRY = (WAIT_STATES == 0) ? ST_SAMPLE : ST_WAIT;

    state_t               state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [LANE_W-1:0]    cnt_q, cnt_d;
    logic [WORD_BITS-1:0] d_q, d_d;
    logic                 expired;

    // Counter is held clear outside the wait phase, so every wait phase
    // starts from zero.
    bus_sizer_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (bus.clk_en),
        .load       (state_q != ST_WAIT),
        .wait_states(4'(WAIT_STATES)),
        .expired    (expired)
    );

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        if (bus.clk_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.memen && bus.start) begin
                        lane_d  = LANE_START;
                        cnt_d   = '0;
                        state_d = CYCLE_ENTRY;
                    end
                end
                ST_WAIT: begin
                    if (!bus.memen) begin
                        state_d = ST_IDLE;
                    end else if (expired) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (!bus.memen) begin
                        state_d = ST_IDLE;
                    end else if (bus.sysrdy) begin
                        for (int k = 0; k < R; k++) begin
                            if (lane_q == LANE_W'(k)) begin
                                d_d[(R-1-k)*NARROW_BITS +: NARROW_BITS] = bus.d8;
                            end
                        end
                        lane_d  = (LOW_FIRST != 0) ? lane_q - LANE_W'(1) : lane_q + LANE_W'(1);
                        cnt_d   = cnt_q + LANE_W'(1);
                        state_d = (cnt_q == LANE_LAST_CNT) ? ST_DONE : CYCLE_ENTRY;
                    end
                end
                ST_DONE: begin
                    if (!bus.memen) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lane_q  <= LANE_START;
            cnt_q   <= '0;
            d_q     <= '1;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        bus.q8 = '0;
        for (int k = 0; k < R; k++) begin
            if (lane_q == LANE_W'(k)) begin
                bus.q8 = bus.q[(R-1-k)*NARROW_BITS +: NARROW_BITS];
            end
        end
    end

    // ready drops combinationally on the request tick so the CPU stalls at once.
    assign bus.ready  = ((state_q == ST_IDLE) && !(bus.memen && bus.start)) ||
                        (state_q == ST_DONE);
    assign bus.memen8 = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign bus.we8    = bus.we && bus.memen8;
    assign bus.lane   = lane_q;
    assign bus.d      = d_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.state  = state_q;

endmodule

// File: tb/tb_bus_sizer.sv
// tb_bus_sizer: randomized self-checking bench for bus_sizer.
//   dut_a: 16->8, 4 wait states, descending lanes (1,0)
//   dut_b: 32->8, no wait states, ascending lanes (0..3)
module tb_bus_sizer;
    import bus_sizer_pkg::*;

    localparam int A_WS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   we8_errs     = 0;
    logic pre_ready;
    int         lanes_q[$];
    logic [7:0] q8s_q[$];
    logic [7:0] mem_a [2];
    logic [7:0] mem_b [4];

    always #5 clk = ~clk;

    bus_sizer_if #(.WORD_BITS(16), .NARROW_BITS(8)) bus_a ();
    bus_sizer_if #(.WORD_BITS(32), .NARROW_BITS(8)) bus_b ();

    bus_sizer #(.WORD_BITS(16), .NARROW_BITS(8), .WAIT_STATES(4), .LOW_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    bus_sizer #(.WORD_BITS(32), .NARROW_BITS(8), .WAIT_STATES(0), .LOW_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    // ---------------- reference model ----------------
    // Word = lanes concatenated with lane 0 as the most significant byte.
    function automatic logic [15:0] model_word_a();
        logic [15:0] w = '0;
        for (int k = 0; k < 2; k++) w = (w << 8) | 16'(mem_a[k]);
        return w;
    endfunction

    function automatic logic [31:0] model_word_b();
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(mem_b[k]);
        return w;
    endfunction

    // ---------------- drivers ----------------
    // One enabled tick, optionally preceded by a disabled clock with junk inputs.
    task automatic tick_a(input logic memen, input logic start, input logic we,
                          input logic sysrdy, input logic [7:0] d8, input logic [15:0] q);
        if ($urandom_range(0, 3) == 0) begin
            bus_a.clk_en = 1'b0;
            bus_a.memen  = 1'($urandom);
            bus_a.start  = 1'($urandom);
            bus_a.sysrdy = 1'($urandom);
            bus_a.d8     = 8'($urandom);
            @(posedge clk); #1;
        end
        bus_a.clk_en = 1'b1;
        bus_a.memen  = memen;
        bus_a.start  = start;
        bus_a.we     = we;
        bus_a.sysrdy = sysrdy;
        bus_a.d8     = d8;
        bus_a.q      = q;
        #1;
        pre_ready = bus_a.ready;
        if (bus_a.we8 !== (we & bus_a.memen8)) we8_errs++;
        @(posedge clk); #1;
        bus_a.clk_en = 1'b0;
    endtask

    task automatic tick_b(input logic memen, input logic start, input logic we,
                          input logic sysrdy, input logic [7:0] d8, input logic [31:0] q);
        if ($urandom_range(0, 3) == 0) begin
            bus_b.clk_en = 1'b0;
            bus_b.memen  = 1'($urandom);
            bus_b.start  = 1'($urandom);
            bus_b.d8     = 8'($urandom);
            @(posedge clk); #1;
        end
        bus_b.clk_en = 1'b1;
        bus_b.memen  = memen;
        bus_b.start  = start;
        bus_b.we     = we;
        bus_b.sysrdy = sysrdy;
        bus_b.d8     = d8;
        bus_b.q      = q;
        #1;
        pre_ready = bus_b.ready;
        if (bus_b.we8 !== (we & bus_b.memen8)) we8_errs++;
        @(posedge clk); #1;
        bus_b.clk_en = 1'b0;
    endtask

    // Full access on dut_a; mem_a answers reads by lane. sysrdy is held low
    // from the first tick after acceptance through tick A_WS+low, which makes
    // the first sample phase see exactly `low` not-ready ticks.
    task automatic access_a(input logic we, input logic [15:0] q, input int low,
                            output int ticks, output logic acc_ready);
        logic sys;
        lanes_q.delete();
        q8s_q.delete();
        tick_a(1'b1, 1'b1, we, 1'b1, 8'h00, q);
        acc_ready = pre_ready;
        ticks = 0;
        while (bus_a.ready !== 1'b1 && ticks < 200) begin
            sys = !(low > 0 && (ticks + 1) <= A_WS + low);
            if (bus_a.memen8 === 1'b1 &&
                (lanes_q.size() == 0 || lanes_q[$] != int'(bus_a.lane))) begin
                lanes_q.push_back(int'(bus_a.lane));
                q8s_q.push_back(bus_a.q8);
            end
            tick_a(1'b1, 1'($urandom), we, sys, mem_a[bus_a.lane], q);
            ticks++;
        end
    endtask

    task automatic access_b(input logic we, input logic [31:0] q, output int ticks);
        lanes_q.delete();
        q8s_q.delete();
        tick_b(1'b1, 1'b1, we, 1'b1, 8'h00, q);
        ticks = 0;
        while (bus_b.ready !== 1'b1 && ticks < 200) begin
            if (bus_b.memen8 === 1'b1 &&
                (lanes_q.size() == 0 || lanes_q[$] != int'(bus_b.lane))) begin
                lanes_q.push_back(int'(bus_b.lane));
                q8s_q.push_back(bus_b.q8);
            end
            tick_b(1'b1, 1'($urandom), we, 1'b1, mem_b[bus_b.lane], q);
            ticks++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        if (bus_a.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_a_ready: got %b expected 1", bus_a.ready); end
        tests_run++;
        if (bus_a.memen8 !== 1'b0) begin tests_failed++; $display("FAIL reset_a_memen8: got %b expected 0", bus_a.memen8); end
        tests_run++;
        if (bus_a.we8 !== 1'b0) begin tests_failed++; $display("FAIL reset_a_we8: got %b expected 0", bus_a.we8); end
        tests_run++;
        if (bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_a_busy: got %b expected 0", bus_a.busy); end
        tests_run++;
        if (bus_a.lane !== 1'b1) begin tests_failed++; $display("FAIL reset_a_lane: got %0d expected 1", bus_a.lane); end
        tests_run++;
        if (bus_a.d !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_a_d: got %h expected ffff", bus_a.d); end
        tests_run++;
        if (bus_b.lane !== 2'd0) begin tests_failed++; $display("FAIL reset_b_lane: got %0d expected 0", bus_b.lane); end
        tests_run++;
        if (bus_b.d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_b_d: got %h expected ffffffff", bus_b.d); end
        tests_run++;
        if (bus_b.ready !== 1'b1 || bus_b.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_b_ready_busy: got %b%b expected 10", bus_b.ready, bus_b.busy);
        end
        tests_run++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fixed();
        int ticks; logic acc_ready;
        mem_a[0] = 8'h12;
        mem_a[1] = 8'h34;
        access_a(1'b0, 16'h0000, 0, ticks, acc_ready);
        if (acc_ready !== 1'b0) begin tests_failed++; $display("FAIL read_ready_on_accept: got %b expected 0", acc_ready); end
        tests_run++;
        if (ticks != 2 * (A_WS + 1)) begin tests_failed++; $display("FAIL read_latency: got %0d expected %0d", ticks, 2 * (A_WS + 1)); end
        tests_run++;
        if (bus_a.d !== 16'h1234) begin tests_failed++; $display("FAIL read_d: got %h expected 1234", bus_a.d); end
        tests_run++;
        if (lanes_q.size() != 2 || lanes_q[0] != 1 || lanes_q[1] != 0) begin
            tests_failed++; $display("FAIL read_lane_seq: got %p expected '{1,0}", lanes_q);
        end
        tests_run++;
        // memen held high in DONE must not retrigger another access
        repeat (3) tick_a(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        if (bus_a.ready !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.d !== 16'h1234) begin
            tests_failed++; $display("FAIL done_hold: got ready=%b busy=%b d=%h expected 1 1 1234", bus_a.ready, bus_a.busy, bus_a.d);
        end
        tests_run++;
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
        if (bus_a.busy !== 1'b0 || bus_a.ready !== 1'b1) begin
            tests_failed++; $display("FAIL done_release: got busy=%b ready=%b expected 0 1", bus_a.busy, bus_a.ready);
        end
        tests_run++;
    endtask

    task automatic test_read_random();
        int ticks; logic acc_ready;
        for (int i = 0; i < 4; i++) begin
            mem_a[0] = 8'($urandom);
            mem_a[1] = 8'($urandom);
            access_a(1'b0, 16'h0000, 0, ticks, acc_ready);
            if (bus_a.d !== model_word_a() || ticks != 2 * (A_WS + 1)) begin
                tests_failed++; $display("FAIL read_random: got d=%h ticks=%0d expected d=%h ticks=%0d", bus_a.d, ticks, model_word_a(), 2 * (A_WS + 1));
            end
            tests_run++;
            tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
        end
    endtask

    task automatic test_write();
        int ticks; logic acc_ready; logic [15:0] q;
        we8_errs = 0;
        for (int i = 0; i < 3; i++) begin
            q = (i == 0) ? 16'hABCD : 16'($urandom);
            access_a(1'b1, q, 0, ticks, acc_ready);
            if (q8s_q.size() != 2 || lanes_q[0] != 1 || q8s_q[0] !== q[7:0] ||
                lanes_q[1] != 0 || q8s_q[1] !== q[15:8]) begin
                tests_failed++; $display("FAIL write_q8: got lanes=%p q8=%p expected lanes 1,0 q8 %h,%h", lanes_q, q8s_q, q[7:0], q[15:8]);
            end
            tests_run++;
            tick_a(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, q);
            if (bus_a.we8 !== 1'b0) begin tests_failed++; $display("FAIL write_we8_idle: got %b expected 0", bus_a.we8); end
            tests_run++;
        end
        if (we8_errs != 0) begin tests_failed++; $display("FAIL we8_gating: got %0d bad samples expected 0", we8_errs); end
        tests_run++;
    endtask

    task automatic test_stall();
        int ticks; logic acc_ready;
        mem_a[0] = 8'($urandom);
        mem_a[1] = 8'($urandom);
        access_a(1'b0, 16'h0000, 3, ticks, acc_ready);
        if (ticks != 2 * (A_WS + 1) + 3) begin tests_failed++; $display("FAIL stall_latency: got %0d expected %0d", ticks, 2 * (A_WS + 1) + 3); end
        tests_run++;
        if (bus_a.d !== model_word_a()) begin tests_failed++; $display("FAIL stall_d: got %h expected %h", bus_a.d, model_word_a()); end
        tests_run++;
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
    endtask

    task automatic test_r4();
        int ticks; logic [31:0] q;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) mem_b[k] = (i == 0) ? 8'(8'h11 * (k + 1)) : 8'($urandom);
            access_b(1'b0, 32'h0, ticks);
            if (bus_b.d !== model_word_b() || ticks != 4) begin
                tests_failed++; $display("FAIL r4_read: got d=%h ticks=%0d expected d=%h ticks=4", bus_b.d, ticks, model_word_b());
            end
            tests_run++;
            if (lanes_q.size() != 4 || lanes_q[0] != 0 || lanes_q[1] != 1 || lanes_q[2] != 2 || lanes_q[3] != 3) begin
                tests_failed++; $display("FAIL r4_lane_seq: got %p expected '{0,1,2,3}", lanes_q);
            end
            tests_run++;
            tick_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        end
        q = 32'($urandom);
        access_b(1'b1, q, ticks);
        if (q8s_q.size() != 4 || q8s_q[0] !== q[31:24] || q8s_q[1] !== q[23:16] ||
            q8s_q[2] !== q[15:8] || q8s_q[3] !== q[7:0]) begin
            tests_failed++; $display("FAIL r4_write_q8: got %p expected q=%h msb first", q8s_q, q);
        end
        tests_run++;
        tick_b(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    endtask

    task automatic test_abort();
        int ticks; logic acc_ready;
        mem_a[0] = 8'h5A;
        mem_a[1] = 8'hC3;
        access_a(1'b0, 16'h0000, 0, ticks, acc_ready);
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
        mem_a[0] = 8'h77;
        mem_a[1] = 8'h99;
        tick_a(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
        // first narrow cycle: A_WS wait ticks + one sample tick
        for (int n = 0; n < A_WS + 1; n++) tick_a(1'b1, 1'b0, 1'b0, 1'b1, mem_a[bus_a.lane], 16'h0000);
        if (bus_a.memen8 !== 1'b1 || bus_a.lane !== 1'b0) begin
            tests_failed++; $display("FAIL abort_second_cycle: got memen8=%b lane=%0d expected 1 0", bus_a.memen8, bus_a.lane);
        end
        tests_run++;
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
        if (bus_a.memen8 !== 1'b0 || bus_a.ready !== 1'b1 || bus_a.busy !== 1'b0) begin
            tests_failed++; $display("FAIL abort_state: got memen8=%b ready=%b busy=%b expected 0 1 0", bus_a.memen8, bus_a.ready, bus_a.busy);
        end
        tests_run++;
        if (bus_a.d !== 16'h5A99) begin tests_failed++; $display("FAIL abort_d: got %h expected 5a99", bus_a.d); end
        tests_run++;
    endtask

    task automatic test_async_reset();
        int ticks; logic acc_ready;
        tick_a(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
        for (int n = 0; n < A_WS + 2; n++) tick_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        if (bus_a.memen8 !== 1'b1 || bus_a.we8 !== 1'b1) begin
            tests_failed++; $display("FAIL async_pre: got memen8=%b we8=%b expected 1 1", bus_a.memen8, bus_a.we8);
        end
        tests_run++;
        bus_a.memen = 1'b0;
        bus_a.start = 1'b0;
        #2 reset = 1'b1;
        #1;
        if (bus_a.memen8 !== 1'b0 || bus_a.we8 !== 1'b0 || bus_a.ready !== 1'b1 ||
            bus_a.busy !== 1'b0 || bus_a.lane !== 1'b1 || bus_a.d !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL async_reset: got memen8=%b we8=%b ready=%b busy=%b lane=%0d d=%h expected 0 0 1 0 1 ffff",
                     bus_a.memen8, bus_a.we8, bus_a.ready, bus_a.busy, bus_a.lane, bus_a.d);
        end
        tests_run++;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        mem_a[0] = 8'($urandom);
        mem_a[1] = 8'($urandom);
        access_a(1'b0, 16'h0000, 0, ticks, acc_ready);
        if (bus_a.d !== model_word_a() || ticks != 2 * (A_WS + 1)) begin
            tests_failed++; $display("FAIL post_reset_read: got d=%h ticks=%0d expected d=%h ticks=%0d", bus_a.d, ticks, model_word_a(), 2 * (A_WS + 1));
        end
        tests_run++;
        tick_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus_a.clk_en = 1'b0; bus_a.memen = 1'b0; bus_a.start = 1'b0; bus_a.we = 1'b0;
        bus_a.sysrdy = 1'b1; bus_a.d8 = 8'h00; bus_a.q = 16'h0000;
        bus_b.clk_en = 1'b0; bus_b.memen = 1'b0; bus_b.start = 1'b0; bus_b.we = 1'b0;
        bus_b.sysrdy = 1'b1; bus_b.d8 = 8'h00; bus_b.q = 32'h0;
        #12;
        test_reset();
        test_read_fixed();
        test_read_random();
        test_write();
        test_stall();
        test_r4();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
